color_sensor_ctrl: RTL and testbench

Parametrised controller for a TCS3200-style light-to-frequency colour sensor. It drives the sensor's filter/scale selects and cycles through the red, blue, green and clear channels. For each channel it counts synchronised sensor edges over a programmable gate window, then classifies the frame into a one-hot colour. It sits between the sensor pins and the rover's navigation logic.

---
 rtl/color_sensor_pkg.sv | 36 +++
 rtl/freq_edge_counter.sv | 51 +++++
 rtl/color_sensor_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_color_sensor_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_sensor_pkg.sv
// Shared definitions for the colour sensor controller.
// Holds the sensor filter select encodings (S2/S3), the one-hot colour codes,
// the controller FSM state type and the channel sequencing helper.
package color_sensor_pkg;

    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    localparam logic [2:0] COL_NONE  = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b001;
    localparam logic [2:0] COL_BLUE  = 3'b010;
    localparam logic [2:0] COL_GREEN = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_CLASSIFY
    } state_t;

    // Channel sequence: red -> blue -> green -> clear (clear wraps to red).
    function automatic logic [1:0] next_filter(input logic [1:0] f);
        logic [1:0] n;
        case (f)
            FILT_RED:   n = FILT_BLUE;
            FILT_BLUE:  n = FILT_GREEN;
            FILT_GREEN: n = FILT_CLEAR;
            default:    n = FILT_RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/freq_edge_counter.sv
// Counts rising edges of an asynchronous pulse train.
// Ports:
//   i_clk, i_rst     system clock, async active-high reset
//   i_sig            raw asynchronous input (never used as a clock)
//   i_clr            synchronous clear of the count (wins over counting)
//   i_cnt_en         count qualifying edges only while high
//   o_count          saturating edge count
module freq_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    input  logic             i_clr,
    input  logic             i_cnt_en,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sync1, r_sync2, r_sync3;
    logic             w_edge;
    logic [CNT_W-1:0] r_count;

    // Two flops resolve metastability; the third holds the previous level
    // so a rising edge becomes a single-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_cnt_en && w_edge && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/color_sensor_ctrl.sv
// TCS3200-style colour sensor controller.
// Sequences the filter through red, blue, green and clear; for each channel
// waits a settle period, counts sensor edges over a gate window, then
// classifies the frame into a one-hot colour.
// Ports:
//   clk, rst        system clock, async active-high reset
//   sensor_freq     raw sensor output (asynchronous)
//   enable          run continuous frames while high
//   scale           sensor S0/S1, constant SCALE_SEL
//   filter          sensor S2/S3 channel select
//   *_cnt           per-channel counts of the last complete frame
//   color           one-hot classification of the last frame
//   valid           one-cycle pulse when color and counts update
//   busy            high whenever a frame is in progress
module color_sensor_ctrl
    import color_sensor_pkg::*;
#(
    parameter int         GATE_CYCLES   = 100000,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         CNT_W         = 16,
    parameter logic [1:0] SCALE_SEL     = 2'b01,
    parameter int         THRESH_R      = 24,
    parameter int         THRESH_B      = 21,
    parameter int         THRESH_G      = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_freq,
    input  logic             enable,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [2:0]       color,
    output logic             valid,
    output logic             busy
);

    localparam int MAXC  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W = $clog2(MAXC + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TH_R = CNT_W'(THRESH_R);
    localparam logic [CNT_W-1:0] TH_B = CNT_W'(THRESH_B);
    localparam logic [CNT_W-1:0] TH_G = CNT_W'(THRESH_G);

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [1:0]       r_filter, w_filter_nxt;
    logic             w_tmr_clr, w_cnt_clr, w_cnt_en, w_store, w_update;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] r_sh_r, r_sh_b, r_sh_g, r_sh_c;
    logic [CNT_W-1:0] r_red, r_blue, r_green, r_clear;
    logic [2:0]       w_color, r_color;
    logic             r_valid;

    freq_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sig   (sensor_freq),
        .i_clr   (w_cnt_clr),
        .i_cnt_en(w_cnt_en),
        .o_count (w_count)
    );

    assign w_cnt_en = (r_state == ST_GATE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_filter_nxt = r_filter;
        w_tmr_clr    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_store      = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt  = ST_SETTLE;
                    w_filter_nxt = FILT_RED;
                    w_tmr_clr    = 1'b1;
                end
            end
            ST_SETTLE: begin
                // Counter is cleared on the way out so edges seen while the
                // filter was switching never reach the gate count.
                if (r_tmr == SETTLE_LAST) begin
                    w_state_nxt = ST_GATE;
                    w_tmr_clr   = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_GATE: begin
                if (r_tmr == GATE_LAST) begin
                    w_state_nxt = ST_STORE;
                    w_tmr_clr   = 1'b1;
                end
            end
            ST_STORE: begin
                w_store = 1'b1;
                if (r_filter == FILT_CLEAR) begin
                    w_state_nxt = ST_CLASSIFY;
                end else begin
                    w_state_nxt  = ST_SETTLE;
                    w_filter_nxt = next_filter(r_filter);
                    w_tmr_clr    = 1'b1;
                end
            end
            ST_CLASSIFY: begin
                w_update     = 1'b1;
                w_filter_nxt = FILT_RED;
                w_tmr_clr    = 1'b1;
                w_state_nxt  = enable ? ST_SETTLE : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr    <= '0;
            r_filter <= FILT_RED;
        end else begin
            r_filter <= w_filter_nxt;
            if (w_tmr_clr)
                r_tmr <= '0;
            else if (r_state == ST_SETTLE || r_state == ST_GATE)
                r_tmr <= r_tmr + 1'b1;
        end
    end

    // Shadow counts collect a full frame before anything is published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_r <= '0;
            r_sh_b <= '0;
            r_sh_g <= '0;
            r_sh_c <= '0;
        end else if (w_store) begin
            case (r_filter)
                FILT_RED:   r_sh_r <= w_count;
                FILT_BLUE:  r_sh_b <= w_count;
                FILT_GREEN: r_sh_g <= w_count;
                default:    r_sh_c <= w_count;
            endcase
        end
    end

    // Strict compares make any tie for the minimum fall through to none.
    always_comb begin
        w_color = COL_NONE;
        if (r_sh_r < r_sh_b && r_sh_r < r_sh_g && r_sh_r < TH_R)
            w_color = COL_RED;
        else if (r_sh_b < r_sh_r && r_sh_b < r_sh_g && r_sh_b < TH_B)
            w_color = COL_BLUE;
        else if (r_sh_g < r_sh_r && r_sh_g < r_sh_b && r_sh_g < TH_G)
            w_color = COL_GREEN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red   <= '0;
            r_blue  <= '0;
            r_green <= '0;
            r_clear <= '0;
            r_color <= COL_NONE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_update;
            if (w_update) begin
                r_red   <= r_sh_r;
                r_blue  <= r_sh_b;
                r_green <= r_sh_g;
                r_clear <= r_sh_c;
                r_color <= w_color;
            end
        end
    end

    assign scale     = SCALE_SEL;
    assign filter    = r_filter;
    assign red_cnt   = r_red;
    assign blue_cnt  = r_blue;
    assign green_cnt = r_green;
    assign clear_cnt = r_clear;
    assign color     = r_color;
    assign valid     = r_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_color_sensor_ctrl.sv
// Bench for color_sensor_ctrl: a frame-timeline model (position within a
// frame, per-channel edge tallies) is checked against the DUT every cycle,
// with literal expectations on directed frames. A second instance with a
// long gate and a free-running input exercises count saturation.
module tb_color_sensor_ctrl;

    localparam int S  = 10;
    localparam int G  = 100;
    localparam int CW = 8;
    localparam int L  = S + G + 1;
    localparam int FR = 4 * L;        // frame position of the classify cycle
    localparam int G2 = 600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sensor = 1'b0;
    logic          enable = 1'b0;
    logic          sat_sens = 1'b0;
    logic [1:0]    scale, filter, s_scale, s_filter;
    logic [CW-1:0] red_cnt, blue_cnt, green_cnt, clear_cnt;
    logic [CW-1:0] s_red, s_blue, s_green, s_clear;
    logic [2:0]    color, s_color;
    logic          valid, busy, s_valid, s_busy;

    always #5 clk = ~clk;

    color_sensor_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .sensor_freq(sensor), .enable(enable),
        .scale(scale), .filter(filter), .red_cnt(red_cnt), .blue_cnt(blue_cnt),
        .green_cnt(green_cnt), .clear_cnt(clear_cnt), .color(color),
        .valid(valid), .busy(busy)
    );

    color_sensor_ctrl #(.GATE_CYCLES(G2), .SETTLE_CYCLES(S), .CNT_W(CW)) u_sat (
        .clk(clk), .rst(rst), .sensor_freq(sat_sens), .enable(enable),
        .scale(s_scale), .filter(s_filter), .red_cnt(s_red), .blue_cnt(s_blue),
        .green_cnt(s_green), .clear_cnt(s_clear), .color(s_color),
        .valid(s_valid), .busy(s_busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_sat = 0;
    bit running = 0;
    bit plan [0:FR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_p = -1;                 // position in frame, -1 when idle
    int acc [4];
    int m_cnt [4];
    int m_col = 0;
    bit m_valid = 0;
    bit h1 = 0, h2 = 0, h3 = 0;   // sensor level 1, 2, 3 cycles ago
    bit m_pulse;
    int m_c, m_q;

    function automatic int classify(input int r, input int b, input int g);
        int mn, nmin;
        mn = r;
        if (b < mn) mn = b;
        if (g < mn) mn = g;
        nmin = 0;
        if (r == mn) nmin++;
        if (b == mn) nmin++;
        if (g == mn) nmin++;
        if (nmin != 1) return 0;
        if (r == mn) return (r < 24) ? 1 : 0;
        if (b == mn) return (b < 21) ? 2 : 0;
        return (g < 19) ? 4 : 0;
    endfunction

    function automatic int exp_filt(input int p);
        int c;
        if (p < 0) return 0;
        c = p / L;
        if (c > 3) c = 3;
        case (c)
            0: return 0;
            1: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    // An input rise in cycle k is seen as an edge during cycle k+2.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p = -1; m_col = 0; m_valid = 0;
            h1 = 0; h2 = 0; h3 = 0;
            for (int i = 0; i < 4; i++) begin acc[i] = 0; m_cnt[i] = 0; end
        end else begin
            m_pulse = h2 && !h3;
            h3 = h2; h2 = h1; h1 = sensor;
            m_valid = 0;
            if (m_p < 0) begin
                if (enable) begin
                    m_p = 0;
                    for (int i = 0; i < 4; i++) acc[i] = 0;
                end
            end else if (m_p == FR) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = acc[i];
                m_col = classify(acc[0], acc[1], acc[2]);
                m_valid = 1;
                m_p = enable ? 0 : -1;
                for (int i = 0; i < 4; i++) acc[i] = 0;
            end else begin
                m_c = m_p / L;
                m_q = m_p % L;
                if (m_pulse && m_q >= S && m_q < S + G && acc[m_c] < 255) acc[m_c]++;
                m_p++;
            end
        end
    end

    always @(negedge clk) begin
        chk("scale", 32'(scale), 1);
        chk("busy", 32'(busy), 32'(m_p >= 0));
        chk("filter", 32'(filter), exp_filt(m_p));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("color", 32'(color), m_col);
        chk("red_cnt", 32'(red_cnt), m_cnt[0]);
        chk("blue_cnt", 32'(blue_cnt), m_cnt[1]);
        chk("green_cnt", 32'(green_cnt), m_cnt[2]);
        chk("clear_cnt", 32'(clear_cnt), m_cnt[3]);
        if (s_valid) begin
            n_sat++;
            chk("sat_red", 32'(s_red), 255);
            chk("sat_blue", 32'(s_blue), 255);
            chk("sat_green", 32'(s_green), 255);
            chk("sat_clear", 32'(s_clear), 255);
            chk("sat_color", 32'(s_color), 0);
        end
    end

    // Saturation instance input: a rise every two cycles, 300 per 600-cycle gate.
    initial begin
        forever begin
            @(posedge clk);
            #1 sat_sens = ~sat_sens;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr_plan();
        for (int i = 0; i <= FR; i++) plan[i] = 0;
    endtask

    // n one-cycle pulses whose edges land on the first n even gate cycles
    task automatic gate_pulses(input int c, input int n);
        for (int j = 0; j < n; j++) plan[c * L + S - 2 + 2 * j] = 1;
    endtask

    task automatic do_frame(input bit keep, input bit lit, input int er, input int eb,
                            input int eg, input int ec, input int ecol);
        if (!running) begin
            enable = 1;
            @(posedge clk); #1;
        end
        for (int i = 0; i <= FR; i++) begin
            sensor = plan[i];
            enable = keep;
            @(posedge clk); #1;
        end
        running = keep;
        chk("frame_len_valid", 32'(valid), 1);
        if (!keep) begin
            chk("busy_fall", 32'(busy), 0);
            sensor = 0;
        end
        if (lit) begin
            chk("lit_red", 32'(red_cnt), er);
            chk("lit_blue", 32'(blue_cnt), eb);
            chk("lit_green", 32'(green_cnt), eg);
            chk("lit_clear", 32'(clear_cnt), ec);
            chk("lit_color", 32'(color), ecol);
        end
    endtask

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_color", 32'(color), 0);
        chk("rst_filter", 32'(filter), 0);
        chk("rst_scale", 32'(scale), 1);
        @(posedge clk); #1;
        rst = 0;

        clr_plan(); gate_pulses(0, 10); gate_pulses(1, 30); gate_pulses(2, 40); gate_pulses(3, 50);
        do_frame(0, 1, 10, 30, 40, 50, 1);

        clr_plan(); gate_pulses(0, 30); gate_pulses(1, 15); gate_pulses(2, 25);
        do_frame(1, 1, 30, 15, 25, 0, 2);
        clr_plan(); gate_pulses(0, 30); gate_pulses(1, 25); gate_pulses(2, 12);
        do_frame(0, 1, 30, 25, 12, 0, 4);

        clr_plan(); gate_pulses(0, 12); gate_pulses(1, 12); gate_pulses(2, 40);
        do_frame(0, 1, 12, 12, 40, 0, 0);
        clr_plan(); gate_pulses(0, 25); gate_pulses(1, 30); gate_pulses(2, 40);
        do_frame(0, 1, 25, 30, 40, 0, 0);

        // edges only while the filter is settling
        clr_plan();
        for (int c = 0; c < 4; c++)
            for (int j = 1; j <= 4; j++) plan[c * L + 2 * j - 2] = 1;
        do_frame(0, 1, 0, 0, 0, 0, 0);

        // red edges on the first and last gate cycles only
        clr_plan(); plan[S - 2] = 1; plan[S + G - 3] = 1;
        gate_pulses(1, 5); gate_pulses(2, 6);
        do_frame(0, 1, 2, 5, 6, 0, 1);

        for (int f = 0; f < 6; f++) begin
            clr_plan();
            if (f % 2 == 0) begin
                for (int c = 0; c < 4; c++) begin
                    int d;
                    d = $urandom_range(5, 60);
                    for (int i = c * L; i < (c + 1) * L; i++)
                        plan[i] = ($urandom_range(0, 99) < d);
                end
            end else begin
                for (int c = 0; c < 4; c++) gate_pulses(c, $urandom_range(5, 35));
            end
            do_frame((f < 5) ? 1'($urandom_range(0, 1)) : 1'b0, 0, 0, 0, 0, 0, 0);
        end

        clr_plan(); gate_pulses(0, 10); gate_pulses(1, 30); gate_pulses(2, 40); gate_pulses(3, 50);
        do_frame(0, 1, 10, 30, 40, 50, 1);

        // reset in the middle of the blue gate
        enable = 1;
        @(posedge clk); #1;
        enable = 0;
        for (int i = 0; i < L + S + 20; i++) begin
            sensor = (i % 2 == 1);
            @(posedge clk); #1;
        end
        chk("mid_blue_filter", 32'(filter), 1);
        rst = 1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_valid", 32'(valid), 0);
        chk("rst_mid_red", 32'(red_cnt), 0);
        chk("rst_mid_color", 32'(color), 0);
        chk("rst_mid_filter", 32'(filter), 0);
        sensor = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        running = 0;

        clr_plan(); gate_pulses(0, 10); gate_pulses(1, 30); gate_pulses(2, 40); gate_pulses(3, 50);
        do_frame(0, 1, 10, 30, 40, 50, 1);

        chk("sat_frame_seen", 32'(n_sat > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
